ahb3lite_master_arb: RTL
========================

AHB3LITE_MASTER_ARB -- requirements
Module: ahb3lite_master_arb

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, the AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, the AHB data width (32 or 64).
REQ-003 SHALL have port HCLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester transfer request, held until accepted.
REQ-006 SHALL have port req_write  input  2  per-requester direction (1 = write).
REQ-007 SHALL have port req_addr  input  2*HADDR_SIZE  packed addresses, port n at [n*HADDR_SIZE +: HADDR_SIZE].
REQ-008 SHALL have port req_wdata  input  2*HDATA_SIZE  packed write data, same packing.
REQ-009 SHALL have port req_size  input  6  packed 3-bit HSIZE codes.
REQ-010 SHALL have port req_accept  output  2  one-hot one-cycle accept pulse.
REQ-011 SHALL have port rsp_valid  output  2  one-hot one-cycle completion pulse.
REQ-012 SHALL have port rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  HDATA_SIZE  read data, qualified by rsp_valid.
REQ-014 SHALL have ports HSEL/HWRITE (1), HADDR (HADDR_SIZE), HWDATA (HDATA_SIZE), HSIZE/HBURST (3), HPROT (4), HTRANS (2), all outputs, AHB3-Lite master side.
REQ-015 SHALL have ports HRDATA (HDATA_SIZE), HREADY (1), HRESP (1), all inputs, from the slave.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, RESP_LOCAL.
REQ-017 IDLE: if any req_valid, SHALL select winner g, pulse req_accept[g] that cycle, latch g's request; next state ADDR, or RESP_LOCAL if the request is illegal.
REQ-018 Illegal request: req_size > log2(HDATA_SIZE/8), or req_addr not aligned to 2^req_size; never issued on the bus.
REQ-019 RESP_LOCAL: SHALL drive rsp_valid[g]=1, rsp_err=1, rsp_rdata=0 for one cycle, then IDLE.
REQ-020 ADDR: SHALL drive HSEL=1, HTRANS=2'b10, HBURST=3'b000, HPROT=4'b0011, latched HADDR/HWRITE/HSIZE; stays in ADDR while HREADY=0, moves to DATA on HREADY=1.
REQ-021 DATA: SHALL drive HSEL=0, HTRANS=2'b00, HWDATA=latched wdata (held whole phase); stays while HREADY=0.
REQ-022 DATA with HREADY=1: SHALL register rsp_valid[g]=1, rsp_err=HRESP, rsp_rdata=HRDATA (read) or 0 (write), visible the next cycle for one cycle; next state IDLE.
REQ-023 HRESP=1 with HREADY=0 (first error cycle): SHALL remain in DATA with HTRANS=IDLE; completion on the second cycle per REQ-022.
REQ-024 Outside ADDR, HADDR/HWRITE/HSIZE SHALL hold their last values; HTRANS SHALL be 2'b00.
REQ-025 Zero-wait latency: accept cycle N, ADDR N+1, DATA N+2, rsp_valid N+3; a new accept is allowed in cycle N+3.
REQ-026 Requests arriving while not in IDLE SHALL wait; no request is dropped.

Reset
REQ-027 HRESET=1 SHALL immediately force IDLE, HTRANS=2'b00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0, HBURST=0, HPROT=0, req_accept=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, last_grant=1.
REQ-028 Reset mid-transfer SHALL abandon the transfer without a rsp_valid pulse.

Configuration
REQ-029 With RR_ARB_EN defined, arbitration SHALL be round-robin: if both valid, grant the port != last_grant; last_grant updates on each accept.
REQ-030 Without RR_ARB_EN, arbitration SHALL be fixed priority, port 0 over port 1; last_grant is unused.

Verification
REQ-031 Port 0 write addr 0x10, data 0xDEADBEEF, size 2, zero wait -> accept[0] cycle N, HTRANS=NONSEQ N+1, HWDATA=0xDEADBEEF N+2, rsp_valid[0]=1, rsp_err=0 N+3.
REQ-032 Port 1 read 0x10 after REQ-031 -> rsp_rdata=0xDEADBEEF, rsp_valid[1] pulse.
REQ-033 Both ports valid continuously, four transfers -> RR_ARB_EN: grants 0,1,0,1; without it: 0,0,0,0.
REQ-034 Slave holds HREADY=0 for 3 DATA cycles -> HWDATA stable, rsp_valid delayed exactly 3 cycles.
REQ-035 Slave two-cycle ERROR -> HTRANS=IDLE both cycles, rsp_err=1 with rsp_valid.
REQ-036 Port 0 size 2 at addr 0x13 -> accepted, no NONSEQ on bus, rsp_valid[0]=1, rsp_err=1 next cycle; HRESET pulsed in DATA -> HTRANS=00 immediately, no rsp_valid.

Source files
------------

// File: rtl/ahb3lite_master_arb.sv
// Two-port request arbiter feeding a single AHB3-Lite master.
// One transfer at a time: IDLE -> ADDR -> DATA -> IDLE, or IDLE -> RESP_LOCAL -> IDLE
// for requests that are rejected locally (oversize or misaligned).
// Optional feature: define RR_ARB_EN for round-robin arbitration (default: port 0 priority).
module ahb3lite_master_arb #(
   parameter int unsigned HADDR_SIZE = 32,
   parameter int unsigned HDATA_SIZE = 32
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [1:0]                req_valid,
   input  logic [1:0]                req_write,
   input  logic [2*HADDR_SIZE-1:0]   req_addr,
   input  logic [2*HDATA_SIZE-1:0]   req_wdata,
   input  logic [5:0]                req_size,
   output logic [1:0]                req_accept,
   output logic [1:0]                rsp_valid,
   output logic                      rsp_err,
   output logic [HDATA_SIZE-1:0]     rsp_rdata,
   output logic                      HSEL,
   output logic                      HWRITE,
   output logic [HADDR_SIZE-1:0]     HADDR,
   output logic [HDATA_SIZE-1:0]     HWDATA,
   output logic [2:0]                HSIZE,
   output logic [2:0]                HBURST,
   output logic [3:0]                HPROT,
   output logic [1:0]                HTRANS,
   input  logic [HDATA_SIZE-1:0]     HRDATA,
   input  logic                      HREADY,
   input  logic                      HRESP
);

   localparam logic [1:0] StIdle      = 2'd0;
   localparam logic [1:0] StAddr      = 2'd1;
   localparam logic [1:0] StData      = 2'd2;
   localparam logic [1:0] StRespLocal = 2'd3;

   // Largest HSIZE code the data bus can carry.
   localparam logic [2:0] MaxSize = 3'($clog2(HDATA_SIZE / 8));

   logic [1:0]            state_q, state_d;
   logic                  gnt;
   logic                  gnt_q;
   logic                  accept;
   logic                  illegal;
   logic [HADDR_SIZE-1:0] sel_addr;
   logic [HDATA_SIZE-1:0] sel_wdata;
   logic [2:0]            sel_size;
   logic                  sel_write;
   logic [7:0]            align_mask;
   logic                  hwrite_q;
   logic [HADDR_SIZE-1:0] haddr_q;
   logic [HDATA_SIZE-1:0] hwdata_q;
   logic [2:0]            hsize_q;
   logic [1:0]            rsp_valid_q;
   logic                  rsp_err_q;
   logic [HDATA_SIZE-1:0] rsp_rdata_q;
`ifdef RR_ARB_EN
   logic                  last_grant_q;
`endif

   // Pick the winning port among the current requesters.
   always_comb begin
`ifdef RR_ARB_EN
      if (&req_valid) gnt = ~last_grant_q;
      else            gnt = ~req_valid[0];
`else
      gnt = ~req_valid[0];
`endif
   end

   // Decode the winner's request and check it for size/alignment legality.
   always_comb begin
      sel_addr   = gnt ? req_addr[HADDR_SIZE +: HADDR_SIZE] : req_addr[0 +: HADDR_SIZE];
      sel_wdata  = gnt ? req_wdata[HDATA_SIZE +: HDATA_SIZE] : req_wdata[0 +: HDATA_SIZE];
      sel_size   = gnt ? req_size[5:3] : req_size[2:0];
      sel_write  = gnt ? req_write[1] : req_write[0];
      align_mask = (8'd1 << sel_size) - 8'd1;
      illegal    = (sel_size > MaxSize) || (|(sel_addr[7:0] & align_mask));
      accept     = (state_q == StIdle) && (|req_valid) && !HRESET;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (accept) state_d = illegal ? StRespLocal : StAddr;
         StAddr:      if (HREADY) state_d = StData;
         StData:      if (HREADY) state_d = StIdle;
         StRespLocal: state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   // State, latched bus fields and registered completion.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q      <= StIdle;
         gnt_q        <= 1'b0;
         hwrite_q     <= 1'b0;
         haddr_q      <= '0;
         hwdata_q     <= '0;
         hsize_q      <= 3'd0;
         rsp_valid_q  <= 2'b00;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
`ifdef RR_ARB_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         if (accept) begin
            gnt_q <= gnt;
`ifdef RR_ARB_EN
            last_grant_q <= gnt;
`endif
            if (illegal) begin
               // Completion shows during the RESP_LOCAL cycle.
               rsp_valid_q <= gnt ? 2'b10 : 2'b01;
               rsp_err_q   <= 1'b1;
            end else begin
               // Bus fields only change for transfers that reach the bus.
               hwrite_q <= sel_write;
               haddr_q  <= sel_addr;
               hwdata_q <= sel_wdata;
               hsize_q  <= sel_size;
            end
         end
         if (state_q == StData && HREADY) begin
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            rsp_err_q   <= HRESP;
            rsp_rdata_q <= hwrite_q ? '0 : HRDATA;
         end
      end
   end

   // Bus control follows the state directly so reset clears it immediately.
   always_comb begin
      HSEL       = (state_q == StAddr);
      HTRANS     = (state_q == StAddr) ? 2'b10 : 2'b00;
      HBURST     = 3'b000;
      HPROT      = (state_q == StAddr) ? 4'b0011 : 4'b0000;
      HWRITE     = hwrite_q;
      HADDR      = haddr_q;
      HWDATA     = hwdata_q;
      HSIZE      = hsize_q;
      req_accept = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      rsp_valid  = rsp_valid_q;
      rsp_err    = rsp_err_q;
      rsp_rdata  = rsp_rdata_q;
   end

endmodule
